apb_regfile_slave: RTL and testbench

APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

---
 rtl/apb_regfile_slave_if.sv | 28 ++
 rtl/apb_regfile_slave.sv | 128 ++++++++++++
 tb/tb_apb_regfile_slave.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_regfile_slave_if.sv
// APB bus bundle between a master and apb_regfile_slave.
// Handshake: a transfer opens with one setup cycle (sel=1, enable=0) and is accepted
// at the first rising edge of the access phase where sel=1, enable=1 and ready=1;
// rdata and slverr are meaningful only in that cycle, and dropping sel aborts.
interface apb_regfile_slave_if;
    logic [31:0] apb_addr_i;
    logic        apb_sel_i;
    logic        apb_enable_i;
    logic        apb_write_i;
    logic [3:0]  apb_strb_i;
    logic [2:0]  apb_prot_i;
    logic [31:0] apb_wdata_i;
    logic        apb_ready_o;
    logic [31:0] apb_rdata_o;
    logic        apb_slverr_o;

    modport slave (
        input  apb_addr_i, apb_sel_i, apb_enable_i, apb_write_i,
        input  apb_strb_i, apb_prot_i, apb_wdata_i,
        output apb_ready_o, apb_rdata_o, apb_slverr_o
    );

    modport master (
        output apb_addr_i, apb_sel_i, apb_enable_i, apb_write_i,
        output apb_strb_i, apb_prot_i, apb_wdata_i,
        input  apb_ready_o, apb_rdata_o, apb_slverr_o
    );
endinterface

// File: rtl/apb_regfile_slave.sv
// APB register file: NUM_REGS RW registers plus ID, free-running CYCLES and a
// saturating ERRCNT, with a fixed number of wait states per access.
module apb_regfile_slave #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h4150_4252
) (
    input  logic               apb_clk_i,
    input  logic               apb_resetn_i,
    apb_regfile_slave_if.slave bus,
    output logic               dbg_state
);
    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] addr_q, wdata_q;
    logic        write_q;
    logic [3:0]  strb_q;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] cycles_q;
    logic [7:0]  errcnt_q;
    logic        setup, complete, ready;

    logic             reg_hit, id_hit, cyc_hit, err_hit, dec_err;
    logic [IDX_W-1:0] reg_idx;
    logic [31:0]      rdata_mux;
    logic             unused_prot;

    // Decode works on the latched address so outputs never depend on live inputs.
    assign reg_hit = (addr_q[1:0] == 2'b00) && (addr_q[31:2] < 30'(NUM_REGS));
    assign reg_idx = addr_q[IDX_W+1:2];
    assign id_hit  = (addr_q == 32'h0000_0100);
    assign cyc_hit = (addr_q == 32'h0000_0104);
    assign err_hit = (addr_q == 32'h0000_0108);
    assign dec_err = !(reg_hit || id_hit || cyc_hit || err_hit)
                   || (write_q && (id_hit || cyc_hit));

    assign unused_prot = ^bus.apb_prot_i;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        setup    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.apb_sel_i && !bus.apb_enable_i) begin
                    setup   = 1'b1;
                    state_d = ACCESS;
                    wait_d  = 4'(WAIT_CYCLES);
                end
            end
            ACCESS: begin
                if (!bus.apb_sel_i) begin
                    state_d = IDLE;
                    wait_d  = 4'd0;
                end else if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else if (bus.apb_enable_i) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                wait_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge apb_clk_i or negedge apb_resetn_i) begin
        if (!apb_resetn_i) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            strb_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (setup) begin
                addr_q  <= bus.apb_addr_i;
                wdata_q <= bus.apb_wdata_i;
                write_q <= bus.apb_write_i;
                strb_q  <= bus.apb_strb_i;
            end
        end
    end

    always_ff @(posedge apb_clk_i or negedge apb_resetn_i) begin
        if (!apb_resetn_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            cycles_q <= '0;
            errcnt_q <= '0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
            if (complete && write_q && !dec_err && reg_hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb_q[b]) regs_q[reg_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
            // A clearing write can never be an errored transfer, so clear simply wins.
            if (complete && write_q && !dec_err && err_hit) begin
                errcnt_q <= '0;
            end else if (complete && dec_err && (errcnt_q != 8'hFF)) begin
                errcnt_q <= errcnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        rdata_mux = '0;
        if (reg_hit)      rdata_mux = regs_q[reg_idx];
        else if (id_hit)  rdata_mux = ID_VALUE;
        else if (cyc_hit) rdata_mux = cycles_q;
        else if (err_hit) rdata_mux = {24'd0, errcnt_q};
    end

    assign ready            = (state_q == ACCESS) && (wait_q == 4'd0);
    assign bus.apb_ready_o  = ready;
    assign bus.apb_slverr_o = ready && dec_err;
    assign bus.apb_rdata_o  = (ready && !write_q && !dec_err) ? rdata_mux : 32'd0;
    assign dbg_state        = (state_q == ACCESS);
endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench: one WAIT_CYCLES=1 slave for the register map and error paths,
// one WAIT_CYCLES=0 slave for back-to-back timing; a select mux steers traffic.
module tb_apb_regfile_slave;
    localparam logic [31:0] ID = 32'h4150_4252;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;

    logic        m_sel, m_en, m_write, use0;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_strb;
    logic [2:0]  m_prot;
    logic        dbg1, dbg0;
    logic        s_ready, s_slverr;
    logic [31:0] s_rdata;

    apb_regfile_slave_if bus1();
    apb_regfile_slave_if bus0();

    apb_regfile_slave #(.NUM_REGS(8), .WAIT_CYCLES(1), .ID_VALUE(ID)) dut (
        .apb_clk_i(clk), .apb_resetn_i(rst_n), .bus(bus1.slave), .dbg_state(dbg1));
    apb_regfile_slave #(.NUM_REGS(8), .WAIT_CYCLES(0), .ID_VALUE(ID)) dut0 (
        .apb_clk_i(clk), .apb_resetn_i(rst_n), .bus(bus0.slave), .dbg_state(dbg0));

    assign bus1.apb_sel_i    = m_sel & ~use0;
    assign bus0.apb_sel_i    = m_sel & use0;
    assign bus1.apb_enable_i = m_en;
    assign bus0.apb_enable_i = m_en;
    assign bus1.apb_write_i  = m_write;
    assign bus0.apb_write_i  = m_write;
    assign bus1.apb_addr_i   = m_addr;
    assign bus0.apb_addr_i   = m_addr;
    assign bus1.apb_wdata_i  = m_wdata;
    assign bus0.apb_wdata_i  = m_wdata;
    assign bus1.apb_strb_i   = m_strb;
    assign bus0.apb_strb_i   = m_strb;
    assign bus1.apb_prot_i   = m_prot;
    assign bus0.apb_prot_i   = m_prot;
    assign s_ready  = use0 ? bus0.apb_ready_o  : bus1.apb_ready_o;
    assign s_slverr = use0 ? bus0.apb_slverr_o : bus1.apb_slverr_o;
    assign s_rdata  = use0 ? bus0.apb_rdata_o  : bus1.apb_rdata_o;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One transfer: returns in the ready cycle with sel/enable still high so the
    // following edge completes it; a subsequent xfer call is then back-to-back.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                        output int waits, output logic leak, output int stamp);
        @(posedge clk); #1;
        m_sel = 1'b1; m_en = 1'b0; m_write = wr; m_addr = addr;
        m_wdata = wdata; m_strb = strb; m_prot = 3'($urandom_range(0, 7));
        @(posedge clk); #1;
        m_en = 1'b1; waits = 0; leak = 1'b0;
        while (!s_ready && waits < 20) begin
            if (s_rdata !== 32'd0 || s_slverr !== 1'b0) leak = 1'b1;
            @(posedge clk); #1;
            waits++;
        end
        rdata = s_rdata; err = s_slverr; stamp = cyc;
        if (s_ready !== 1'b1) begin
            checks++;
            $display("FAIL xfer_timeout: addr %h ready=%b after %0d cycles, required 1", addr, s_ready, waits);
            m_sel = 1'b0; m_en = 1'b0;
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        m_sel = 1'b0; m_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er, lk; int wt, st;
        rst_n = 1'b0; use0 = 1'b0;
        m_sel = 1'b0; m_en = 1'b0; m_write = 1'b0; m_addr = '0; m_wdata = '0; m_strb = '0; m_prot = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus1.apb_ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus1.apb_ready_o); else passes++;
        checks++; if (bus1.apb_rdata_o !== 32'd0) $display("FAIL reset_rdata: got %h want 0", bus1.apb_rdata_o); else passes++;
        checks++; if (bus1.apb_slverr_o !== 1'b0) $display("FAIL reset_slverr: got %b want 0", bus1.apb_slverr_o); else passes++;
        checks++; if (dbg1 !== 1'b0) $display("FAIL reset_state: got %b want 0", dbg1); else passes++;
        @(negedge clk) rst_n = 1'b1;
        xfer(1'b0, 32'h00C, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (rd !== 32'd0) $display("FAIL reset_reg3: got %h want 0", rd); else passes++;
        idle();
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er, lk; int wt, st;
        xfer(1'b1, 32'h004, 32'h1234_5678, 4'hF, rd, er, wt, lk, st);
        checks++; if (er !== 1'b0) $display("FAIL basic_wr_err: got %b want 0", er); else passes++;
        checks++; if (wt != 1) $display("FAIL basic_wr_waits: got %0d want 1", wt); else passes++;
        xfer(1'b0, 32'h004, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (rd !== 32'h1234_5678) $display("FAIL basic_rdata: got %h want 12345678", rd); else passes++;
        checks++; if (er !== 1'b0) $display("FAIL basic_rd_err: got %b want 0", er); else passes++;
        checks++; if (wt != 1) $display("FAIL basic_rd_waits: got %0d want 1", wt); else passes++;
        checks++; if (lk !== 1'b0) $display("FAIL basic_idle_outputs: nonzero rdata/slverr=%b while not ready, want 0", lk); else passes++;
        idle();
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic er, lk; int wt, st;
        xfer(1'b1, 32'h000, 32'hFFFF_FFFF, 4'hF, rd, er, wt, lk, st);
        xfer(1'b1, 32'h000, 32'h0000_0000, 4'h5, rd, er, wt, lk, st);
        xfer(1'b0, 32'h000, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (rd !== 32'hFF00_FF00) $display("FAIL strobe_5: got %h want ff00ff00", rd); else passes++;
        xfer(1'b1, 32'h000, 32'h1234_5678, 4'h0, rd, er, wt, lk, st);
        checks++; if (er !== 1'b0) $display("FAIL strobe_0_err: got %b want 0", er); else passes++;
        xfer(1'b0, 32'h000, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (rd !== 32'hFF00_FF00) $display("FAIL strobe_0_noop: got %h want ff00ff00", rd); else passes++;
        xfer(1'b1, 32'h01C, 32'hAABB_CCDD, 4'hA, rd, er, wt, lk, st);
        xfer(1'b0, 32'h01C, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (rd !== 32'hAA00_CC00) $display("FAIL strobe_a_reg7: got %h want aa00cc00", rd); else passes++;
        idle();
    endtask

    task automatic test_id_errors();
        logic [31:0] rd; logic er, lk; int wt, st;
        xfer(1'b0, 32'h100, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (rd !== ID) $display("FAIL id_read: got %h want %h", rd, ID); else passes++;
        xfer(1'b1, 32'h104, 32'h5555_5555, 4'hF, rd, er, wt, lk, st);
        checks++; if (er !== 1'b1) $display("FAIL cycles_write_err: got %b want 1", er); else passes++;
        xfer(1'b0, 32'h108, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (rd !== 32'd1) $display("FAIL errcnt_1: got %h want 1", rd); else passes++;
        xfer(1'b0, 32'h0FC, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (er !== 1'b1) $display("FAIL unmapped_err: got %b want 1", er); else passes++;
        checks++; if (rd !== 32'd0) $display("FAIL unmapped_rdata: got %h want 0", rd); else passes++;
        xfer(1'b0, 32'h108, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (rd !== 32'd2) $display("FAIL errcnt_2: got %h want 2", rd); else passes++;
        xfer(1'b0, 32'h1000_0004, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (er !== 1'b1) $display("FAIL alias_err: got %b want 1", er); else passes++;
        xfer(1'b0, 32'h020, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (er !== 1'b1) $display("FAIL beyond_regs_err: got %b want 1", er); else passes++;
        xfer(1'b1, 32'h100, 32'h0, 4'hF, rd, er, wt, lk, st);
        checks++; if (er !== 1'b1) $display("FAIL id_write_err: got %b want 1", er); else passes++;
        xfer(1'b0, 32'h108, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (rd !== 32'd5) $display("FAIL errcnt_5: got %h want 5", rd); else passes++;
        xfer(1'b1, 32'h108, $urandom, 4'h0, rd, er, wt, lk, st);
        checks++; if (er !== 1'b0) $display("FAIL errcnt_clear_err: got %b want 0", er); else passes++;
        xfer(1'b0, 32'h108, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (rd !== 32'd0) $display("FAIL errcnt_cleared: got %h want 0", rd); else passes++;
        idle();
    endtask

    task automatic test_saturate();
        logic [31:0] rd; logic er, lk; int wt, st; int errs;
        xfer(1'b1, 32'h00D, 32'hFFFF_FFFF, 4'hF, rd, er, wt, lk, st);
        checks++; if (er !== 1'b1) $display("FAIL misaligned_wr_err: got %b want 1", er); else passes++;
        xfer(1'b0, 32'h00C, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (rd !== 32'd0) $display("FAIL misaligned_no_update: got %h want 0", rd); else passes++;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            xfer(1'b0, 32'h001, '0, 4'h0, rd, er, wt, lk, st);
            if (er === 1'b1) errs++;
        end
        checks++; if (errs != 300) $display("FAIL misaligned_errs: got %0d want 300", errs); else passes++;
        xfer(1'b0, 32'h108, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (rd !== 32'h0000_00FF) $display("FAIL errcnt_sat: got %h want ff", rd); else passes++;
        xfer(1'b0, 32'h001, '0, 4'h0, rd, er, wt, lk, st);
        xfer(1'b0, 32'h108, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (rd !== 32'h0000_00FF) $display("FAIL errcnt_sat_hold: got %h want ff", rd); else passes++;
        xfer(1'b1, 32'h108, 32'h0, 4'hF, rd, er, wt, lk, st);
        idle();
    endtask

    task automatic test_abort_reset();
        logic [31:0] rd; logic er, lk; int wt, st;
        logic [31:0] addrs [4];
        addrs = '{32'h000, 32'h004, 32'h008, 32'h01C};
        xfer(1'b1, 32'h008, 32'hA5A5_A5A5, 4'hF, rd, er, wt, lk, st);
        @(posedge clk); #1;
        m_sel = 1'b1; m_en = 1'b0; m_write = 1'b1; m_addr = 32'h008; m_wdata = 32'hDEAD_BEEF; m_strb = 4'hF;
        @(posedge clk); #1;
        checks++; if (dbg1 !== 1'b1) $display("FAIL abort_in_access: got %b want 1", dbg1); else passes++;
        m_sel = 1'b0; m_en = 1'b0;
        @(posedge clk); #1;
        checks++; if (dbg1 !== 1'b0) $display("FAIL abort_to_idle: got %b want 0", dbg1); else passes++;
        xfer(1'b0, 32'h008, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (rd !== 32'hA5A5_A5A5) $display("FAIL abort_reg2: got %h want a5a5a5a5", rd); else passes++;
        xfer(1'b0, 32'h108, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (rd !== 32'd0) $display("FAIL abort_errcnt: got %h want 0", rd); else passes++;
        xfer(1'b0, 32'h000, '0, 4'h0, rd, er, wt, lk, st);
        checks++; if (rd !== 32'hFF00_FF00) $display("FAIL prereset_rdata: got %h want ff00ff00", rd); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus1.apb_ready_o !== 1'b0) $display("FAIL midreset_ready: got %b want 0", bus1.apb_ready_o); else passes++;
        checks++; if (bus1.apb_rdata_o !== 32'd0) $display("FAIL midreset_rdata: got %h want 0", bus1.apb_rdata_o); else passes++;
        checks++; if (dbg1 !== 1'b0) $display("FAIL midreset_state: got %b want 0", dbg1); else passes++;
        m_sel = 1'b0; m_en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, addrs[i], '0, 4'h0, rd, er, wt, lk, st);
            checks++; if (rd !== 32'd0) $display("FAIL postreset_reg %h: got %h want 0", addrs[i], rd); else passes++;
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, c1, c2, c3; logic er, lk; int w1, w2, s1, s2, s3;
        use0 = 1'b1;
        xfer(1'b0, 32'h104, '0, 4'h0, c1, er, w1, lk, s1);
        xfer(1'b0, 32'h104, '0, 4'h0, c2, er, w2, lk, s2);
        checks++; if (w1 != 0 || w2 != 0) $display("FAIL b2b_waits: got %0d,%0d want 0,0", w1, w2); else passes++;
        checks++; if (s2 - s1 != 2) $display("FAIL b2b_spacing: got %0d cycles want 2", s2 - s1); else passes++;
        checks++; if (c2 - c1 !== 32'd2) $display("FAIL b2b_cycles_delta: got %0d want 2", c2 - c1); else passes++;
        idle();
        repeat (5) @(posedge clk);
        xfer(1'b0, 32'h104, '0, 4'h0, c3, er, w1, lk, s3);
        checks++; if (c3 - c2 !== 32'(s3 - s2)) $display("FAIL cycles_delta: got %0d want %0d", c3 - c2, s3 - s2); else passes++;
        xfer(1'b0, 32'h100, '0, 4'h0, rd, er, w1, lk, s1);
        checks++; if (rd !== ID || er !== 1'b0) $display("FAIL zw_id: got %h/%b want %h/0", rd, er, ID); else passes++;
        idle();
        use0 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_id_errors();
        test_saturate();
        test_abort_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
